// File: rtl/game_state_ctrl.sv
// game_state_ctrl: Bomberman game sequencer (lives, freeze/respawn, overlay select).
// Optional SCORE_EN adds a saturating 12-bit kill/clean-win score output.
module game_state_ctrl #(
  parameter int LIVES_INIT    = 3,
  parameter int FREEZE_FRAMES = 60,
  parameter int FLASH_SHIFT   = 3,
  parameter int N_ENEMY       = 6
) (
  input  logic               sys_clk,
  input  logic               Reset,
  input  logic               v_sync,
  input  logic               move_req,
  input  logic               start_pulse,
  input  logic               player_hit,
  input  logic               bomb_hit,
  input  logic [N_ENEMY-1:0] enemy_killed,
  output logic               enemies_run,
  output logic               player_en,
  output logic               respawn,
  output logic [2:0]         lives,
  output logic [1:0]         screen_mode,
  output logic [2:0]         state_dbg
`ifdef SCORE_EN
  ,output logic [11:0]       score
`endif
);
  typedef enum logic [2:0] {IDLE = 3'd0, PLAY = 3'd1, DYING = 3'd2, LOSE = 3'd3, WIN = 3'd4} state_t;
  localparam int FW = FLASH_SHIFT + 1;
  state_t state_q, state_d;
  logic [2:0] vs_q;
  logic [7:0] cnt_q, cnt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic flash_q, flash_d, respawn_q, respawn_d;
  logic [2:0] lives_q, lives_d;
  logic enemies_run_q, enemies_run_d, player_en_q, player_en_d;
  logic [1:0] screen_mode_q, screen_mode_d;
  logic frame_tick, hit, all_dead, fcnt_last, restart;
  assign frame_tick = vs_q[2] & ~vs_q[1];
  assign hit        = player_hit | bomb_hit;
  assign all_dead   = &enemy_killed;
  assign fcnt_last  = fcnt_q == FW'((1 << FLASH_SHIFT) - 1);
  assign restart    = (state_q == LOSE || state_q == WIN) && start_pulse;
  always_ff @(posedge sys_clk or posedge Reset)
    if (Reset) begin
      vs_q          <= '0;
      state_q       <= IDLE;
      cnt_q         <= '0;
      fcnt_q        <= '0;
      flash_q       <= 1'b0;
      lives_q       <= 3'(LIVES_INIT);
      respawn_q     <= 1'b0;
      enemies_run_q <= 1'b0;
      player_en_q   <= 1'b1;
      screen_mode_q <= 2'b00;
    end else begin
      vs_q          <= {vs_q[1:0], v_sync};
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fcnt_q        <= fcnt_d;
      flash_q       <= flash_d;
      lives_q       <= lives_d;
      respawn_q     <= respawn_d;
      enemies_run_q <= enemies_run_d;
      player_en_q   <= player_en_d;
      screen_mode_q <= screen_mode_d;
    end
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    cnt_d     = cnt_q;
    fcnt_d    = fcnt_q;
    flash_d   = flash_q;
    respawn_d = 1'b0;
    case (state_q)
      IDLE: state_d = move_req ? PLAY : IDLE;
      PLAY:
        if (hit) begin
          lives_d = lives_q > 3'd1 ? lives_q - 3'd1 : 3'd0;
          state_d = lives_q > 3'd1 ? DYING : LOSE;
          cnt_d   = 8'(FREEZE_FRAMES);
          fcnt_d  = '0;
          flash_d = 1'b0;
        end else if (all_dead) state_d = WIN;
      DYING:
        if (frame_tick) begin
          cnt_d   = cnt_q - 8'd1;
          fcnt_d  = fcnt_last ? '0 : fcnt_q + FW'(1);
          flash_d = flash_q ^ fcnt_last;
          if (cnt_q <= 8'd1) begin
            state_d   = IDLE;
            respawn_d = 1'b1;
            cnt_d     = '0;
            fcnt_d    = '0;
            flash_d   = 1'b0;
          end
        end
      LOSE, WIN:
        if (start_pulse) begin
          state_d   = IDLE;
          lives_d   = 3'(LIVES_INIT);
          respawn_d = 1'b1;
        end
      default: state_d = IDLE;
    endcase
  end
  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    enemies_run_d = state_d == PLAY;
    player_en_d   = state_d == IDLE || state_d == PLAY;
    screen_mode_d = state_d == LOSE ? 2'b01 : state_d == WIN ? 2'b10 :
                    (state_d == DYING && flash_d) ? 2'b11 : 2'b00;
  end
  assign enemies_run = enemies_run_q;
  assign player_en   = player_en_q;
  assign respawn     = respawn_q;
  assign lives       = lives_q;
  assign screen_mode = screen_mode_q;
  assign state_dbg   = state_q;
`ifdef SCORE_EN
  logic [N_ENEMY-1:0] ek_q;
  logic bonus_q, bonus_d;
  logic [11:0] score_q, score_d;
  logic [15:0] sum;
  // The clean-win bonus lands one cycle after WIN entry, after the final kill is counted.
  always_comb begin
    bonus_d = state_d == WIN && state_q != WIN && lives_q == 3'(LIVES_INIT);
    sum     = {4'd0, score_q} + (bonus_q ? 16'd500 : 16'd0);
    for (int i = 0; i < N_ENEMY; i++) sum = sum + ((enemy_killed[i] & ~ek_q[i]) ? 16'd100 : 16'd0);
    score_d = restart ? 12'd0 : sum > 16'd4095 ? 12'hfff : sum[11:0];
  end
  always_ff @(posedge sys_clk or posedge Reset)
    if (Reset) begin
      ek_q    <= '0;
      bonus_q <= 1'b0;
      score_q <= '0;
    end else begin
      ek_q    <= enemy_killed;
      bonus_q <= bonus_d;
      score_q <= score_d;
    end
  assign score = score_q;
`endif
endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: scoreboard bench for game_state_ctrl (FREEZE_FRAMES=8, FLASH_SHIFT=1).
module tb_game_state_ctrl;
  localparam int S_IDLE = 0, S_PLAY = 1, S_DYING = 2, S_LOSE = 3, S_WIN = 4;
  logic sys_clk = 1'b0, Reset = 1'b1, v_sync = 1'b0, move_req = 1'b0, start_pulse = 1'b0;
  logic player_hit = 1'b0, bomb_hit = 1'b0;
  logic [5:0] enemy_killed = '0;
  logic enemies_run, player_en, respawn;
  logic [2:0] lives, state_dbg;
  logic [1:0] screen_mode;
`ifdef SCORE_EN
  logic [11:0] score;
  logic [11:0] ssb[$];
  logic [11:0] se;
`endif
  int vectors = 0, miscompares = 0;
  logic [10:0] sb[$];
  logic [10:0] e;
  always #5 sys_clk = ~sys_clk;
  game_state_ctrl #(.LIVES_INIT(3), .FREEZE_FRAMES(8), .FLASH_SHIFT(1), .N_ENEMY(6)) dut (
    .sys_clk(sys_clk), .Reset(Reset), .v_sync(v_sync), .move_req(move_req),
    .start_pulse(start_pulse), .player_hit(player_hit), .bomb_hit(bomb_hit),
    .enemy_killed(enemy_killed), .enemies_run(enemies_run), .player_en(player_en),
    .respawn(respawn), .lives(lives), .screen_mode(screen_mode), .state_dbg(state_dbg)
`ifdef SCORE_EN
    , .score(score)
`endif
  );
  function automatic logic [10:0] obs();
    return {state_dbg, lives, screen_mode, enemies_run, player_en, respawn};
  endfunction
  function automatic logic [10:0] pack(int st, int lv, int sm, int er, int pe, int rs);
    return {3'(st), 3'(lv), 2'(sm), 1'(er), 1'(pe), 1'(rs)};
  endfunction
  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask
  task automatic fall();
    v_sync = 1'b1;
    repeat (3) cyc();
    v_sync = 1'b0;
  endtask
  task automatic frame();
    fall();
    repeat (3) cyc();
  endtask
  task automatic wait_respawn();
    int n = 0;
    while (respawn !== 1'b1 && n < 8) begin
      cyc();
      n++;
    end
  endtask

  task automatic test_reset();
    repeat (3) cyc();
    Reset = 1'b0;
    sb.push_back(pack(S_IDLE, 3, 0, 0, 1, 0));
    vectors++; e = sb.pop_front();
    if (obs() !== e) begin miscompares++; $display("FAIL reset: got %h expected %h", obs(), e); end
    player_hit = 1'b1; start_pulse = 1'b1;
    sb.push_back(pack(S_IDLE, 3, 0, 0, 1, 0));
    cyc();
    player_hit = 1'b0; start_pulse = 1'b0;
    vectors++; e = sb.pop_front();
    if (obs() !== e) begin miscompares++; $display("FAIL idle_ignores_hit: got %h expected %h", obs(), e); end
  endtask

  task automatic test_start();
    move_req = 1'b1;
    sb.push_back(pack(S_PLAY, 3, 0, 1, 1, 0));
    cyc();
    move_req = 1'b0;
    vectors++; e = sb.pop_front();
    if (obs() !== e) begin miscompares++; $display("FAIL start_play: got %h expected %h", obs(), e); end
    start_pulse = 1'b1;
    sb.push_back(pack(S_PLAY, 3, 0, 1, 1, 0));
    cyc();
    start_pulse = 1'b0;
    vectors++; e = sb.pop_front();
    if (obs() !== e) begin miscompares++; $display("FAIL play_ignores_start: got %h expected %h", obs(), e); end
  endtask

  task automatic test_dying();
    player_hit = 1'b1;
    sb.push_back(pack(S_DYING, 2, 0, 0, 0, 0));
    cyc();
    player_hit = 1'b0;
    vectors++; e = sb.pop_front();
    if (obs() !== e) begin miscompares++; $display("FAIL hit_to_dying: got %h expected %h", obs(), e); end
    for (int i = 1; i < 8; i++) begin
      sb.push_back(pack(S_DYING, 2, ((i / 2) % 2) != 0 ? 3 : 0, 0, 0, 0));
      frame();
      vectors++; e = sb.pop_front();
      if (obs() !== e) begin miscompares++; $display("FAIL dying_tick%0d: got %h expected %h", i, obs(), e); end
      if (i == 3) begin
        bomb_hit = 1'b1; enemy_killed = 6'h3f;
        sb.push_back(pack(S_DYING, 2, 3, 0, 0, 0));
        cyc();
        bomb_hit = 1'b0; enemy_killed = '0;
        vectors++; e = sb.pop_front();
        if (obs() !== e) begin miscompares++; $display("FAIL dying_ignores_hit: got %h expected %h", obs(), e); end
      end
    end
    sb.push_back(pack(S_IDLE, 2, 0, 0, 1, 1));
    fall();
    wait_respawn();
    vectors++; e = sb.pop_front();
    if (obs() !== e) begin miscompares++; $display("FAIL dying_respawn: got %h expected %h", obs(), e); end
    sb.push_back(pack(S_IDLE, 2, 0, 0, 1, 0));
    cyc();
    vectors++; e = sb.pop_front();
    if (obs() !== e) begin miscompares++; $display("FAIL respawn_one_cycle: got %h expected %h", obs(), e); end
  endtask

  task automatic test_reset_mid_dying();
    move_req = 1'b1;
    cyc();
    move_req = 1'b0;
    player_hit = 1'b1;
    sb.push_back(pack(S_DYING, 1, 0, 0, 0, 0));
    cyc();
    player_hit = 1'b0;
    vectors++; e = sb.pop_front();
    if (obs() !== e) begin miscompares++; $display("FAIL second_hit: got %h expected %h", obs(), e); end
    repeat (5) frame();
    Reset = 1'b1;
    #1;
    sb.push_back(pack(S_IDLE, 3, 0, 0, 1, 0));
    vectors++; e = sb.pop_front();
    if (obs() !== e) begin miscompares++; $display("FAIL async_reset: got %h expected %h", obs(), e); end
    repeat (2) cyc();
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(pack(S_IDLE, 3, 0, 0, 1, 0));
      cyc();
      vectors++; e = sb.pop_front();
      if (obs() !== e) begin miscompares++; $display("FAIL post_reset_no_respawn%0d: got %h expected %h", i, obs(), e); end
    end
  endtask

  task automatic test_lose();
    for (int k = 0; k < 2; k++) begin
      move_req = 1'b1;
      cyc();
      move_req = 1'b0;
      player_hit = 1'b1;
      sb.push_back(pack(S_DYING, 2 - k, 0, 0, 0, 0));
      cyc();
      player_hit = 1'b0;
      vectors++; e = sb.pop_front();
      if (obs() !== e) begin miscompares++; $display("FAIL lose_hit%0d: got %h expected %h", k, obs(), e); end
      repeat (7) frame();
      sb.push_back(pack(S_IDLE, 2 - k, 0, 0, 1, 1));
      fall();
      wait_respawn();
      vectors++; e = sb.pop_front();
      if (obs() !== e) begin miscompares++; $display("FAIL lose_respawn%0d: got %h expected %h", k, obs(), e); end
    end
    move_req = 1'b1;
    cyc();
    move_req = 1'b0;
    player_hit = 1'b1;
    sb.push_back(pack(S_LOSE, 0, 1, 0, 0, 0));
    cyc();
    player_hit = 1'b0;
    vectors++; e = sb.pop_front();
    if (obs() !== e) begin miscompares++; $display("FAIL enter_lose: got %h expected %h", obs(), e); end
    move_req = 1'b1; player_hit = 1'b1;
    sb.push_back(pack(S_LOSE, 0, 1, 0, 0, 0));
    cyc();
    move_req = 1'b0; player_hit = 1'b0;
    vectors++; e = sb.pop_front();
    if (obs() !== e) begin miscompares++; $display("FAIL lose_holds: got %h expected %h", obs(), e); end
    start_pulse = 1'b1;
    sb.push_back(pack(S_IDLE, 3, 0, 0, 1, 1));
    cyc();
    start_pulse = 1'b0;
    vectors++; e = sb.pop_front();
    if (obs() !== e) begin miscompares++; $display("FAIL lose_restart: got %h expected %h", obs(), e); end
    sb.push_back(pack(S_IDLE, 3, 0, 0, 1, 0));
    cyc();
    vectors++; e = sb.pop_front();
    if (obs() !== e) begin miscompares++; $display("FAIL lose_restart_pulse: got %h expected %h", obs(), e); end
  endtask

  task automatic test_hit_vs_win();
    move_req = 1'b1;
    cyc();
    move_req = 1'b0;
    enemy_killed = 6'h3f; bomb_hit = 1'b1;
    sb.push_back(pack(S_DYING, 2, 0, 0, 0, 0));
    cyc();
    enemy_killed = '0; bomb_hit = 1'b0;
    vectors++; e = sb.pop_front();
    if (obs() !== e) begin miscompares++; $display("FAIL hit_beats_win: got %h expected %h", obs(), e); end
    repeat (7) frame();
    sb.push_back(pack(S_IDLE, 2, 0, 0, 1, 1));
    fall();
    wait_respawn();
    vectors++; e = sb.pop_front();
    if (obs() !== e) begin miscompares++; $display("FAIL win_test_respawn: got %h expected %h", obs(), e); end
    move_req = 1'b1;
    cyc();
    move_req = 1'b0;
    enemy_killed = 6'h3f;
    sb.push_back(pack(S_WIN, 2, 2, 0, 0, 0));
    cyc();
    vectors++; e = sb.pop_front();
    if (obs() !== e) begin miscompares++; $display("FAIL enter_win: got %h expected %h", obs(), e); end
    start_pulse = 1'b1;
    sb.push_back(pack(S_IDLE, 3, 0, 0, 1, 1));
    cyc();
    start_pulse = 1'b0;
    enemy_killed = '0;
    vectors++; e = sb.pop_front();
    if (obs() !== e) begin miscompares++; $display("FAIL win_restart: got %h expected %h", obs(), e); end
    cyc();
  endtask

`ifdef SCORE_EN
  task automatic test_score();
    logic [5:0] seq [4] = '{6'b000010, 6'b000100, 6'b010000, 6'b100000};
    ssb.push_back(12'd0);
    cyc();
    vectors++; se = ssb.pop_front();
    if (score !== se) begin miscompares++; $display("FAIL score_restart: got %0d expected %0d", score, se); end
    move_req = 1'b1;
    cyc();
    move_req = 1'b0;
    enemy_killed = 6'b001001;
    ssb.push_back(12'd200);
    cyc();
    vectors++; se = ssb.pop_front();
    if (score !== se) begin miscompares++; $display("FAIL score_double: got %0d expected %0d", score, se); end
    for (int i = 0; i < 4; i++) begin
      enemy_killed = enemy_killed | seq[i];
      ssb.push_back(12'(300 + 100 * i));
      cyc();
      vectors++; se = ssb.pop_front();
      if (score !== se) begin miscompares++; $display("FAIL score_kill%0d: got %0d expected %0d", i, score, se); end
    end
    sb.push_back(pack(S_WIN, 3, 2, 0, 0, 0));
    vectors++; e = sb.pop_front();
    if (obs() !== e) begin miscompares++; $display("FAIL score_win_state: got %h expected %h", obs(), e); end
    ssb.push_back(12'd1100);
    ssb.push_back(12'd1100);
    for (int i = 0; i < 2; i++) begin
      cyc();
      vectors++; se = ssb.pop_front();
      if (score !== se) begin miscompares++; $display("FAIL score_bonus%0d: got %0d expected %0d", i, score, se); end
    end
    start_pulse = 1'b1;
    ssb.push_back(12'd0);
    cyc();
    start_pulse = 1'b0;
    enemy_killed = '0;
    vectors++; se = ssb.pop_front();
    if (score !== se) begin miscompares++; $display("FAIL score_reload: got %0d expected %0d", score, se); end
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_dying();
    test_reset_mid_dying();
    test_lose();
    test_hit_vs_win();
`ifdef SCORE_EN
    test_score();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
- Central game sequencer for the Bomberman datapath.
- Collects hit, bomb-kill and enemy-killed status from the bomberman, enemy and bomb blocks, and tracks lives.
- Decides when enemies may move and when the player is frozen or respawned.
- Selects the full-screen overlay mode used by the top-level pixel mux. This replaces the direct "game_over || death_signal → red" and "all killed → green" logic.

Parameters:
- LIVES_INIT, 3: lives loaded at reset and at restart; legal range 1..7.
- FREEZE_FRAMES, 60: frames the player/enemies stay frozen after losing a life; legal range 1..255.
- FLASH_SHIFT, 3: overlay flash toggles every 2^FLASH_SHIFT frames during the death freeze.
- N_ENEMY, 6: number of enemy_killed inputs.

Ports:
- sys_clk  in  1  100 MHz system clock
- Reset  in  1  asynchronous, active-high reset
- v_sync  in  1  VGA vSync from display_controller; a frame tick is its 1→0 edge
- move_req  in  1  OR of debounced L/R/U/D buttons
- start_pulse  in  1  single-cycle centre-button pulse (SCEN)
- player_hit  in  1  OR of all enemy death signals
- bomb_hit  in  1  bomberman game_over (caught in explosion)
- enemy_killed  in  N_ENEMY  per-enemy killed flags (level-sensitive, sticky in the enemy blocks)
- enemies_run  out  1  enemy movement enable (replaces enemy_start)
- player_en  out  1  bomberman movement/bomb-drop enable
- respawn  out  1  one-cycle pulse; bomberman and enemies return to start positions
- lives  out  3  remaining lives
- screen_mode  out  2  00 normal sprites, 01 solid red, 10 solid green, 11 flash (black)
- state_dbg  out  3  current FSM state encoding

Behaviour:
- v_sync is double-flopped before use. frame_tick is a one-cycle pulse on the synchronized 1→0 transition.
- All outputs are registered. Reset values:
  - state IDLE, enemies_run 0, player_en 1, respawn 0
  - lives = LIVES_INIT, screen_mode 00, freeze counter 0, flash phase 0
- hit = player_hit | bomb_hit. all_dead = AND of enemy_killed[N_ENEMY-1:0].
- FSM states (state_dbg encoding):
  - IDLE (0): enemies_run 0, player_en 1, screen_mode 00. move_req=1 → PLAY on the next cycle. hit is ignored.
  - PLAY (1): enemies_run 1, player_en 1, screen_mode 00. Evaluated in this priority order:
    - hit with lives==1 → lives 0, LOSE.
    - hit with lives>1 → lives−1, freeze counter = FREEZE_FRAMES, DYING.
    - all_dead (and no hit) → WIN.
    - A hit and all_dead in the same cycle resolve as a hit.
  - DYING (2): enemies_run 0, player_en 0.
    - screen_mode = 11 while flash phase is 1, otherwise 00. Flash phase toggles on every 2^FLASH_SHIFT-th frame_tick and starts at 0 on entry.
    - Each frame_tick decrements the counter. When the counter reaches 0: respawn=1 for exactly one cycle, then IDLE.
    - hit and all_dead are ignored in this state.
  - LOSE (3): enemies_run 0, player_en 0, screen_mode 01.
  - WIN (4): enemies_run 0, player_en 0, screen_mode 10.
  - From LOSE or WIN, start_pulse=1 → lives reload to LIVES_INIT, respawn=1 for one cycle, then IDLE.
  - Unused encodings → IDLE.
- start_pulse in IDLE, PLAY or DYING has no effect; the centre button stays the bomb-drop key in those states.
- Lives never underflow: the decrement happens only when lives>1.
- Reset asserted mid-sequence (including mid-DYING or during a respawn pulse) returns every output to its reset value immediately. No respawn pulse is generated by Reset itself; the submodules reset on the same signal.
- frame_tick arriving in the same cycle as a state entry is not counted for the new state.

Optional Feature:
- Macro SCORE_EN.
- Defined:
  - Adds output score [11:0], reset 0 and reloaded to 0 on restart.
  - Each 0→1 transition of any enemy_killed bit, detected against a registered copy, adds 100. Several bits rising in the same cycle add 100 each.
  - Saturates at 4095.
  - A LIVES_INIT-lives clean win (no lives lost) adds a one-time 500 bonus on entry to WIN.
- Not defined: no score port, no edge-detect registers.

Test Plan:
- Reset, then move_req=1 for one cycle → state PLAY next cycle, enemies_run=1, lives=3, screen_mode=00.
- FREEZE_FRAMES=2, in PLAY pulse player_hit → lives=2, state DYING, enemies_run=0, player_en=0. After 2 frame_ticks → respawn high exactly one cycle, then IDLE.
- Three hits with a respawn and move_req between each → lives 3→2→1→0; third hit enters LOSE with screen_mode=01. start_pulse → lives=3, respawn pulse, IDLE.
- enemy_killed=6'b111111 and bomb_hit=1 in the same PLAY cycle → hit wins: lives decrements, DYING, not WIN. Later all_dead alone in PLAY → WIN, screen_mode=10.
- FLASH_SHIFT=1, FREEZE_FRAMES=8 → screen_mode alternates 00/11 every 2 frame_ticks during DYING. Assert Reset at tick 5 → IDLE, lives=3, no respawn pulse.
- With SCORE_EN: kill enemies 0 and 3 in the same cycle, then the rest one by one with no lives lost → score=600 at all_dead, then 1100 after WIN entry.
